// File: rtl/tinyml_axi_rr_arbiter.sv
// Registered N-way request arbiter with fixed-priority or round-robin selection
// and optional grant holding until request drop or acknowledge.
module tinyml_axi_rr_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_BLOCK             = 1,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EW-1:0]    grant_encoded
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state, state_next;
  logic [PORTS-1:0] mask, mask_next, masked, grant_next;
  logic [EW-1:0]    winner, enc_next;
  logic             release_now, load_mask;

  // Priority encoder: index of the highest-priority set bit (0 if none).
  function automatic logic [EW-1:0] pick(input logic [PORTS-1:0] v);
    logic [EW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) begin
        if (v[PORTS-1-i]) idx = EW'(PORTS-1-i);
      end else begin
        if (v[i]) idx = EW'(i);
      end
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '1;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      grant_valid   <= (state_next == GRANTED);
      grant_encoded <= enc_next;
      if (load_mask) mask <= mask_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    enc_next    = grant_encoded;
    load_mask   = 1'b0;
    release_now = 1'b0;
    masked      = request & mask;

    if (ARB_TYPE_ROUND_ROBIN != 0 && masked != '0) winner = pick(masked);
    else winner = pick(request);

    // Next round-robin search window starts just past the winner in priority order.
    mask_next = '1;
    if (ARB_TYPE_ROUND_ROBIN != 0) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (ARB_LSB_HIGH_PRIORITY != 0) mask_next[i] = (EW'(i) > winner);
        else mask_next[i] = (EW'(i) < winner);
      end
    end

    unique case (state)
      IDLE: release_now = 1'b1;
      GRANTED: begin
        if (ARB_BLOCK == 0)          release_now = 1'b1;
        else if (ARB_BLOCK_ACK != 0) release_now = acknowledge[grant_encoded];
        else                         release_now = !request[grant_encoded];
      end
      default: release_now = 1'b1;
    endcase

    if (release_now) begin
      if (request != '0) begin
        state_next = GRANTED;
        grant_next = PORTS'(1) << winner;
        enc_next   = winner;
        load_mask  = 1'b1;
      end else begin
        state_next = IDLE;
        grant_next = '0;
        enc_next   = '0;
      end
    end
  end

endmodule

// File: tb/tb_tinyml_axi_rr_arbiter.sv
// Directed checks of the arbiter across round-robin, fixed-priority,
// acknowledge-hold and request-hold configurations.
module tb_tinyml_axi_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] acknowledge = '0;

  logic [3:0] g_rr, g_fp, g_ack, g_req;
  logic       v_rr, v_fp, v_ack, v_req;
  logic [1:0] e_rr, e_fp, e_ack, e_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tinyml_axi_rr_arbiter #(
    .PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0),
    .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)
  ) u_rr (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr)
  );

  tinyml_axi_rr_arbiter #(
    .PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
    .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)
  ) u_fp (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g_fp), .grant_valid(v_fp), .grant_encoded(e_fp)
  );

  tinyml_axi_rr_arbiter #(
    .PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
    .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)
  ) u_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack)
  );

  tinyml_axi_rr_arbiter #(
    .PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
    .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)
  ) u_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g_req), .grant_valid(v_req), .grant_encoded(e_req)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] req);
    rst = 1'b1;
    request = req;
    acknowledge = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    request = 4'b1111;
    acknowledge = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({g_rr, v_rr, e_rr} !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got grant=%b valid=%b enc=%0d exp 0000/0/0", i, g_rr, v_rr, e_rr);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (g_rr !== 4'b0001 || v_rr !== 1'b1 || e_rr !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant got grant=%b valid=%b enc=%0d exp 0001/1/0", g_rr, v_rr, e_rr);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [1:0] exp_e [4];
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_e = '{2'd0, 2'd1, 2'd3, 2'd0};
    apply_reset(4'b1011);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (g_rr !== exp_g[i] || e_rr !== exp_e[i] || v_rr !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d] got grant=%b enc=%0d valid=%b exp %b/%0d/1", i, g_rr, e_rr, v_rr, exp_g[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset(4'b1100);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (g_fp !== 4'b0100 || e_fp !== 2'd2) begin
        errors++;
        $display("FAIL fp_hi[%0d] got grant=%b enc=%0d exp 0100/2", i, g_fp, e_fp);
      end
    end
    request = 4'b1101;
    step();
    checks++;
    if (g_fp !== 4'b0001 || e_fp !== 2'd0) begin
      errors++;
      $display("FAIL fp_bit0 got grant=%b enc=%0d exp 0001/0", g_fp, e_fp);
    end
  endtask

  task automatic test_ack_hold();
    apply_reset(4'b0110);
    step();
    checks++;
    if (g_ack !== 4'b0010 || e_ack !== 2'd1) begin
      errors++;
      $display("FAIL ack_first got grant=%b enc=%0d exp 0010/1", g_ack, e_ack);
    end
    request = 4'b0100;
    acknowledge = 4'b0100;
    step();
    acknowledge = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (g_ack !== 4'b0010 || v_ack !== 1'b1) begin
        errors++;
        $display("FAIL ack_hold[%0d] got grant=%b valid=%b exp 0010/1", i, g_ack, v_ack);
      end
      step();
    end
    acknowledge = 4'b0010;
    step();
    acknowledge = '0;
    checks++;
    if (g_ack !== 4'b0100 || e_ack !== 2'd2) begin
      errors++;
      $display("FAIL ack_release got grant=%b enc=%0d exp 0100/2", g_ack, e_ack);
    end
  endtask

  task automatic test_request_hold();
    apply_reset(4'b1001);
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g_req !== 4'b0001 || v_req !== 1'b1) begin
        errors++;
        $display("FAIL req_hold[%0d] got grant=%b valid=%b exp 0001/1", i, g_req, v_req);
      end
      step();
    end
    request = 4'b1000;
    step();
    checks++;
    if (g_req !== 4'b1000 || e_req !== 2'd3) begin
      errors++;
      $display("FAIL req_release got grant=%b enc=%0d exp 1000/3", g_req, e_req);
    end
    request = 4'b0000;
    step();
    checks++;
    if (g_req !== 4'b0000 || v_req !== 1'b0 || e_req !== 2'd0) begin
      errors++;
      $display("FAIL req_idle got grant=%b valid=%b enc=%0d exp 0000/0/0", g_req, v_req, e_req);
    end
    acknowledge = 4'b1111;
    step();
    acknowledge = '0;
    checks++;
    if (v_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got valid=%b exp 0", v_req);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset(4'b0100);
    step();
    step();
    checks++;
    if (g_ack !== 4'b0100) begin
      errors++;
      $display("FAIL mid_setup got grant=%b exp 0100", g_ack);
    end
    rst = 1'b1;
    step();
    checks++;
    if (g_ack !== 4'b0000 || v_ack !== 1'b0 || e_ack !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got grant=%b valid=%b enc=%0d exp 0000/0/0", g_ack, v_ack, e_ack);
    end
    rst = 1'b0;
    request = 4'b0101;
    step();
    checks++;
    if (g_ack !== 4'b0001 || e_ack !== 2'd0) begin
      errors++;
      $display("FAIL mid_regrant got grant=%b enc=%0d exp 0001/0", g_ack, e_ack);
    end
  endtask

  // Round-robin after mask history: granting port 1 then port 2 must follow.
  task automatic test_back_to_back();
    apply_reset(4'b0010);
    step();
    request = 4'b0111;
    step();
    checks++;
    if (g_rr !== 4'b0100 || e_rr !== 2'd2) begin
      errors++;
      $display("FAIL b2b_wrap got grant=%b enc=%0d exp 0100/2", g_rr, e_rr);
    end
    step();
    checks++;
    if (g_rr !== 4'b0001 || e_rr !== 2'd0) begin
      errors++;
      $display("FAIL b2b_wrap0 got grant=%b enc=%0d exp 0001/0", g_rr, e_rr);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_ack_hold();
    test_request_hold();
    test_reset_mid_grant();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tinyml_axi_rr_arbiter.md
Name: tinyml_axi_rr_arbiter

Overview:
- Registered N-way arbiter that shares one AXI resource (interconnect slave slot, DMA channel, accelerator port) between PORTS requesters.
- Selects a winner each arbitration cycle in fixed-priority or round-robin mode, using the team's priority-encoder primitive.
- Optionally holds the grant until the winner drops its request or acknowledges completion.
- Grant outputs drive the downstream mux select and handshake gating directly.

Parameters:
- PORTS, 4, number of requesters; >=1.
- ARB_TYPE_ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority.
- ARB_BLOCK, 1, 1 = hold the grant once issued; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 1, used when ARB_BLOCK=1. 1 = release on acknowledge; 0 = release when the granted request deasserts.
- ARB_LSB_HIGH_PRIORITY, 1, 1 = index 0 has highest static priority; 0 = index PORTS-1 does.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, synchronous reset, active-high.
- request, input, PORTS, per-port request level.
- acknowledge, input, PORTS, per-port completion strobe; sampled only on the granted bit.
- grant, output, PORTS, one-hot grant, registered.
- grant_valid, output, 1, registered; high iff grant != 0.
- grant_encoded, output, $clog2(PORTS) (1 when PORTS=1), index of the granted port, registered.

Behaviour:
- Reset: while rst is high on a clk edge, grant=0, grant_valid=0, grant_encoded=0, and the round-robin mask is cleared to all-ones (no history).
  - rst mid-transaction drops the grant on the next edge regardless of hold state.
- Latency: a request asserted in cycle t with the arbiter free produces grant in cycle t+1. Outputs are never combinational from inputs.
- States:
  - IDLE (grant_valid=0).
  - GRANTED (grant_valid=1, holding index g).
- IDLE: if request != 0, arbitrate and go to GRANTED with the winner. Otherwise stay in IDLE.
- GRANTED, release condition:
  - ARB_BLOCK=0: always released.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=0: release when request[g]=0.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=1: release when acknowledge[g]=1. request[g] dropping does not release.
- On release in cycle t, arbitration runs in the same cycle t over the current request vector. The new grant (possibly the same port) is registered at t+1, so there are no idle bubbles. If request=0, go to IDLE.
- No release: grant, grant_valid and grant_encoded hold unchanged. Requests and acknowledges on other ports are ignored.
- Arbitration, fixed priority: the winner is the highest-priority set bit of request per ARB_LSB_HIGH_PRIORITY.
- Arbitration, round-robin:
  - Masked candidate set = request & mask. The winner is the highest-priority bit of the masked set if it is nonzero; otherwise the highest-priority bit of the unmasked request.
  - After granting g with ARB_LSB_HIGH_PRIORITY=1: mask = bits strictly above g (next search starts at g+1 and wraps to 0).
  - ARB_LSB_HIGH_PRIORITY=0: mask = bits strictly below g.
  - The mask updates only when a new grant is registered.
- One-hot invariant: grant has at most one bit set. grant_encoded matches grant whenever grant_valid=1.
- PORTS=1: grant = the request registered under the hold rules. Round-robin degenerates to fixed priority.
- Acknowledge on a non-granted port, or while IDLE: no effect.

Test Plan:
- Reset: drive request=4'b1111 with rst high for 3 cycles -> grant=0, grant_valid=0, grant_encoded=0 throughout. First grant is 4'b0001 one cycle after rst falls.
- Round-robin, ARB_BLOCK=0, request held at 4'b1011 -> successive grants 0001, 0010, 1000, 0001, with grant_encoded 0, 1, 3, 0. No idle cycles.
- Fixed priority (ARB_TYPE_ROUND_ROBIN=0), ARB_BLOCK=0, request=4'b1100 -> grant=0100 every cycle. Raise bit 0 -> grant=0001 the next cycle.
- Acknowledge hold (ARB_BLOCK=1, ARB_BLOCK_ACK=1): request=4'b0110 -> grant=0010.
  - Drop request[1] and pulse acknowledge[2] -> grant stays 0010.
  - Pulse acknowledge[1] -> next cycle grant=0100.
- Request hold (ARB_BLOCK_ACK=0): grant 0001 held for 5 cycles while request[0]=1 and request[3]=1. Deassert request[0] -> next cycle grant=1000. With request=0 -> grant_valid=0.
- Reset mid-grant: while holding grant=0100, assert rst for one cycle -> grant=0 on the next edge. With request=4'b0101, the first post-reset grant is 0001 (mask cleared).
